// File: rtl/cpu_pkg.sv
// Shared CPU constants, state encoding and instruction payload layout.
// Consumed by instr_mem_loader and instr_ram (parity option: INSTR_MEM_PARITY_EN).
package cpu_pkg;

   localparam int unsigned INSTR_W   = 9;
   localparam int unsigned ADDR_W    = 8;
   localparam int unsigned OPC_W     = 3;
   localparam int unsigned REG_AW    = 2;
   localparam int unsigned DEPTH     = 1 << ADDR_W;
   localparam int unsigned CNT_W     = ADDR_W + 1;
   localparam int unsigned LAST_ADDR = DEPTH - 1;

   typedef enum logic [1:0] {
      S_CLEAR = 2'b00,
      S_LOAD  = 2'b01,
      S_RUN   = 2'b10
   } state_t;

   typedef struct packed {
      logic [OPC_W-1:0]  opcode;
      logic [REG_AW-1:0] ra1;
      logic [REG_AW-1:0] ra2;
      logic [REG_AW-1:0] wa;
   } instr_t;

   localparam logic [INSTR_W-1:0] NOP_WORD = '0;

   // Even parity over one stored instruction word.
   function automatic logic even_parity(input logic [INSTR_W-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/instr_ram.sv
// Program storage: one write port, one registered read port that returns NOP when disabled.
// Define INSTR_MEM_PARITY_EN to store a parity bit per word and flag mismatches on read.
module instr_ram
   import cpu_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               we,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [INSTR_W-1:0] wr_data,
   input  logic               rd_en,
   input  logic [ADDR_W-1:0]  rd_addr,
`ifdef INSTR_MEM_PARITY_EN
   output logic [INSTR_W-1:0] rd_data,
   output logic               rd_perr
`else
   output logic [INSTR_W-1:0] rd_data
`endif
);

`ifdef INSTR_MEM_PARITY_EN
   localparam int unsigned MEM_W = INSTR_W + 1;
`else
   localparam int unsigned MEM_W = INSTR_W;
`endif

   logic [MEM_W-1:0] mem [DEPTH];
   logic [MEM_W-1:0] rd_word;

   // Storage is deliberately not reset; the clear sweep defines its contents.
   always_ff @(posedge clk) begin
      if (we) begin
`ifdef INSTR_MEM_PARITY_EN
         mem[wr_addr] <= {even_parity(wr_data), wr_data};
`else
         mem[wr_addr] <= wr_data;
`endif
      end
   end

   assign rd_word = mem[rd_addr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data <= NOP_WORD;
      end else if (rd_en) begin
         rd_data <= rd_word[INSTR_W-1:0];
      end else begin
         rd_data <= NOP_WORD;
      end
   end

`ifdef INSTR_MEM_PARITY_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_perr <= 1'b0;
      end else if (rd_en) begin
         rd_perr <= rd_word[INSTR_W] ^ even_parity(rd_word[INSTR_W-1:0]);
      end else begin
         rd_perr <= 1'b0;
      end
   end
`endif

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory with valid/ready program load and auto-clear; holds the CPU in reset
// until contents are runnable. Define INSTR_MEM_PARITY_EN to add per-word parity and parity_err.
module instr_mem_loader
   import cpu_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [ADDR_W-1:0]  pc,
   output logic [INSTR_W-1:0] instr,
   input  logic               load_start,
   input  logic               load_valid,
   input  logic [INSTR_W-1:0] load_data,
   input  logic               load_last,
   output logic               load_ready,
   output logic               cpu_reset,
   output logic [CNT_W-1:0]   prog_len,
`ifdef INSTR_MEM_PARITY_EN
   output logic               busy,
   output logic               parity_err
`else
   output logic               busy
`endif
);

   state_t             state;
   state_t             state_next;
   logic [ADDR_W-1:0]  wr_addr;
   logic [ADDR_W-1:0]  wr_addr_next;
   logic [CNT_W-1:0]   prog_len_next;
   logic               we_c;
   logic [INSTR_W-1:0] wdata_c;
   logic               rd_en_c;

   // Next-state, write-port and length logic.
   always_comb begin
      state_next    = state;
      wr_addr_next  = wr_addr;
      prog_len_next = prog_len;
      we_c          = 1'b0;
      wdata_c       = NOP_WORD;

      case (state)
         S_CLEAR: begin
            we_c         = 1'b1;
            wr_addr_next = wr_addr + ADDR_W'(1);
            if (wr_addr == ADDR_W'(LAST_ADDR)) begin
               state_next = S_RUN;
            end
         end
         S_RUN: begin
            if (load_start) begin
               wr_addr_next = '0;
               state_next   = S_LOAD;
            end
         end
         S_LOAD: begin
            if (load_valid && load_ready) begin
               we_c         = 1'b1;
               wdata_c      = load_data;
               wr_addr_next = wr_addr + ADDR_W'(1);
               // A full memory leaves nothing to clear, so it wins over load_last.
               if (wr_addr == ADDR_W'(LAST_ADDR)) begin
                  prog_len_next = CNT_W'(DEPTH);
                  state_next    = S_RUN;
               end else if (load_last) begin
                  prog_len_next = CNT_W'(wr_addr) + CNT_W'(1);
                  state_next    = S_CLEAR;
               end
            end
         end
         default: begin
            wr_addr_next = '0;
            state_next   = S_CLEAR;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_CLEAR;
         wr_addr  <= '0;
         prog_len <= '0;
      end else begin
         state    <= state_next;
         wr_addr  <= wr_addr_next;
         prog_len <= prog_len_next;
      end
   end

   // Status outputs are registered from the next state so they track the state exactly.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         load_ready <= 1'b0;
         cpu_reset  <= 1'b1;
         busy       <= 1'b1;
      end else begin
         load_ready <= (state_next == S_LOAD);
         cpu_reset  <= (state_next != S_RUN);
         busy       <= (state_next != S_RUN);
      end
   end

   assign rd_en_c = (state == S_RUN);

   instr_ram u_ram (
      .clk     (clk),
      .reset   (reset),
      .we      (we_c),
      .wr_addr (wr_addr),
      .wr_data (wdata_c),
      .rd_en   (rd_en_c),
      .rd_addr (pc),
`ifdef INSTR_MEM_PARITY_EN
      .rd_data (instr),
      .rd_perr (parity_err)
`else
      .rd_data (instr)
`endif
   );

endmodule
